// File: rtl/divider_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | divider_arbiter_if                                                   |
// | Requester-side request/response bundle shared by all requesters.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface divider_arbiter_if #(
  parameter int NUM_REQ = 2
) ();

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0][31:0] req_dividend;
  logic [NUM_REQ-1:0][15:0] req_divisor;
  logic [NUM_REQ-1:0]       req_is_8_bit;
  logic [NUM_REQ-1:0]       req_is_signed;

  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic [15:0]              rsp_quotient;
  logic [15:0]              rsp_remainder;
  logic                     rsp_error;
  logic                     rsp_timeout;

  modport master (
    output req_valid, req_dividend, req_divisor, req_is_8_bit, req_is_signed, rsp_ready,
    input  req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_error, rsp_timeout
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor, req_is_8_bit, req_is_signed, rsp_ready,
    output req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_error, rsp_timeout
  );

endinterface
`default_nettype wire

// File: rtl/divider_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | divider_arbiter                                                      |
// | Round-robin sharing of one Divider with held operands, held response |
// | handshake and a watchdog that turns a hung divider into an error.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module divider_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 31
) (
  input  wire               clk,
  input  wire               reset_n,
  divider_arbiter_if.slave  bus,
  output logic              arb_busy,
  output logic              div_start,
  output logic              div_is_8_bit,
  output logic              div_is_signed,
  output logic [31:0]       div_dividend,
  output logic [15:0]       div_divisor,
  input  wire               div_complete,
  input  wire               div_error,
  input  wire  [15:0]       div_quotient,
  input  wire  [15:0]       div_remainder
);

  localparam int                   c_grant_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [c_grant_w-1:0] c_last    = c_grant_w'(NUM_REQ - 1);
  localparam logic [7:0]           c_wd_last = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;

  logic [c_grant_w-1:0]   r_rr_ptr;
  logic [c_grant_w-1:0]   r_grant;
  logic [31:0]            r_dividend;
  logic [15:0]            r_divisor;
  logic                   r_is_8_bit;
  logic                   r_is_signed;
  logic [7:0]             r_wd_cnt;
  logic [15:0]            r_quotient;
  logic [15:0]            r_remainder;
  logic                   r_error;
  logic                   r_timeout;

  logic                   w_found;
  logic [c_grant_w-1:0]   w_grant;
  logic [31:0]            w_idx;
  logic                   w_accept;
  logic                   w_timeout;
  logic                   w_rsp_fire;

  // Scan from the round-robin pointer upward, wrapping, first set bit wins.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = 32'(r_rr_ptr) + 32'(i);
      if (w_idx >= 32'(NUM_REQ)) begin
        w_idx = w_idx - 32'(NUM_REQ);
      end
      if (!w_found && bus.req_valid[w_idx[c_grant_w-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_idx[c_grant_w-1:0];
      end
    end
  end

  assign w_accept   = (r_state == ST_IDLE) && w_found;
  assign w_timeout  = (r_state == ST_WAIT) && (r_wd_cnt == c_wd_last);
  assign w_rsp_fire = (r_state == ST_RESPOND) && bus.rsp_ready[r_grant];

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_next_state = ST_START;
      ST_START:   w_next_state = ST_WAIT;
      ST_WAIT:    if (div_complete || w_timeout) w_next_state = ST_RESPOND;
      ST_RESPOND: if (w_rsp_fire) w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_is_8_bit  <= 1'b0;
      r_is_signed <= 1'b0;
      r_wd_cnt    <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_error     <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_grant     <= w_grant;
            r_dividend  <= bus.req_dividend[w_grant];
            r_divisor   <= bus.req_divisor[w_grant];
            r_is_8_bit  <= bus.req_is_8_bit[w_grant];
            r_is_signed <= bus.req_is_signed[w_grant];
          end
        end
        ST_START: begin
          r_wd_cnt <= '0;
        end
        ST_WAIT: begin
          r_wd_cnt <= r_wd_cnt + 8'd1;
          // A completion arriving on the timeout cycle still delivers real results.
          if (div_complete) begin
            r_quotient  <= div_quotient;
            r_remainder <= div_remainder;
            r_error     <= div_error;
            r_timeout   <= 1'b0;
          end else if (w_timeout) begin
            r_quotient  <= '0;
            r_remainder <= '0;
            r_error     <= 1'b1;
            r_timeout   <= 1'b1;
          end
        end
        ST_RESPOND: begin
          if (w_rsp_fire) begin
            r_rr_ptr <= (r_grant == c_last) ? '0 : r_grant + c_grant_w'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // req_ready is masked during reset so no request is reported as taken while state is frozen.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign bus.req_ready[g] = reset_n && w_accept && (w_grant == c_grant_w'(g));
    assign bus.rsp_valid[g] = (r_state == ST_RESPOND) && (r_grant == c_grant_w'(g));
  end

  assign bus.rsp_quotient  = r_quotient;
  assign bus.rsp_remainder = r_remainder;
  assign bus.rsp_error     = r_error;
  assign bus.rsp_timeout   = r_timeout;

  assign arb_busy      = (r_state != ST_IDLE);
  assign div_start     = (r_state == ST_START);
  assign div_dividend  = r_dividend;
  assign div_divisor   = r_divisor;
  assign div_is_8_bit  = r_is_8_bit;
  assign div_is_signed = r_is_signed;

endmodule
`default_nettype wire

// File: tb/tb_divider_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_divider_arbiter                                                   |
// | Directed bench with a behavioural divider and a response scoreboard. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_divider_arbiter;

  localparam int NUM_REQ = 2;
  localparam int TIMEOUT = 24;
  localparam int DIV_LAT = 19;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arb_busy;
  logic        div_start;
  logic        div_is_8_bit;
  logic        div_is_signed;
  logic [31:0] div_dividend;
  logic [15:0] div_divisor;
  logic        div_complete  = 1'b0;
  logic        div_error     = 1'b0;
  logic [15:0] div_quotient  = 16'd0;
  logic [15:0] div_remainder = 16'd0;

  divider_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  divider_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .reset_n       (rst_n),
    .bus           (bus),
    .arb_busy      (arb_busy),
    .div_start     (div_start),
    .div_is_8_bit  (div_is_8_bit),
    .div_is_signed (div_is_signed),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_complete  (div_complete),
    .div_error     (div_error),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          req;
    logic [15:0] q;
    logic [15:0] r;
    logic        err;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  bit   hang     = 1'b0;

  // Behavioural divider: reads its operand pins when it finishes, so unstable operands corrupt the result.
  int dv_cnt  = 0;
  bit dv_busy = 1'b0;

  function automatic bit model_bad();
    logic [31:0] qq;
    if (div_is_8_bit) begin
      if (div_divisor[7:0] == 8'd0) return 1'b1;
      qq = 32'(div_dividend[15:0]) / 32'(div_divisor[7:0]);
      return qq > 32'hFF;
    end
    if (div_divisor == 16'd0) return 1'b1;
    qq = div_dividend / 32'(div_divisor);
    return qq > 32'hFFFF;
  endfunction

  always @(negedge clk) begin
    div_complete = 1'b0;
    if (!rst_n) begin
      dv_busy = 1'b0;
      dv_cnt  = 0;
    end else if (dv_busy) begin
      dv_cnt--;
      if (dv_cnt == 0) begin
        dv_busy = 1'b0;
        div_complete = 1'b1;
        if (model_bad()) begin
          div_error = 1'b1; div_quotient = 16'd0; div_remainder = 16'd0;
        end else if (div_is_8_bit) begin
          div_error     = 1'b0;
          div_quotient  = 16'(32'(div_dividend[15:0]) / 32'(div_divisor[7:0]));
          div_remainder = 16'(32'(div_dividend[15:0]) % 32'(div_divisor[7:0]));
        end else begin
          div_error     = 1'b0;
          div_quotient  = 16'(div_dividend / 32'(div_divisor));
          div_remainder = 16'(div_dividend % 32'(div_divisor));
        end
      end
    end else if (div_start && !hang) begin
      dv_busy = 1'b1;
      dv_cnt  = model_bad() ? 1 : DIV_LAT;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(1) << e.req);
      chk({tag, "_quotient"},  32'(bus.rsp_quotient), 32'(e.q));
      chk({tag, "_remainder"}, 32'(bus.rsp_remainder), 32'(e.r));
      chk({tag, "_error"},     32'(bus.rsp_error), 32'(e.err));
      chk({tag, "_timeout"},   32'(bus.rsp_timeout), 32'(e.to));
    end
  endtask

  task automatic run_op(input string tag, input int r, input logic [31:0] dd, input logic [15:0] dv,
                        input bit b8, input bit sg, input logic [15:0] eq, input logic [15:0] er,
                        input bit ee, input bit et, input int lat, input int hold, input bit both);
    int          n;
    int          o;
    logic [15:0] q0;
    logic [15:0] r0;
    o = 1 - r;
    sb.push_back('{req: r, q: eq, r: er, err: ee, to: et});
    @(negedge clk);
    bus.req_valid[r]     = 1'b1;
    bus.req_dividend[r]  = dd;
    bus.req_divisor[r]   = dv;
    bus.req_is_8_bit[r]  = b8;
    bus.req_is_signed[r] = sg;
    if (both) bus.req_valid[o] = 1'b1;
    #1;
    n = 0;
    while (bus.req_ready == '0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, "_accept"}, 32'(bus.req_ready), 32'(1) << r);
    @(negedge clk);
    bus.req_valid[r] = 1'b0;
    if (both) bus.req_valid[o] = 1'b0;
    #1;
    chk({tag, "_div_start"}, 32'(div_start), 32'd1);
    chk({tag, "_div_dividend"}, div_dividend, dd);
    chk({tag, "_div_divisor"}, 32'(div_divisor), 32'(dv));
    chk({tag, "_div_mode"}, 32'({div_is_8_bit, div_is_signed}), 32'({b8, sg}));
    n = 0;
    do begin
      @(negedge clk); #1; n++;
      if (n == 1) chk({tag, "_start_once"}, 32'(div_start), 32'd0);
    end while (bus.rsp_valid == '0 && n < TIMEOUT + 10);
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_held_dividend"}, div_dividend, dd);
    if (hold > 0) begin
      q0 = bus.rsp_quotient;
      r0 = bus.rsp_remainder;
      bus.req_valid[o] = 1'b1;
      bus.rsp_ready[o] = 1'b1;
      repeat (hold) begin
        @(negedge clk); #1;
        chk({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'(1) << r);
        chk({tag, "_hold_q"}, 32'(bus.rsp_quotient), 32'(q0));
        chk({tag, "_hold_r"}, 32'(bus.rsp_remainder), 32'(r0));
        chk({tag, "_hold_no_ready"}, 32'(bus.req_ready), 32'd0);
      end
      bus.req_valid[o] = 1'b0;
      bus.rsp_ready[o] = 1'b0;
    end
    sb_check(tag);
    bus.rsp_ready[r] = 1'b1;
    @(negedge clk);
    bus.rsp_ready[r] = 1'b0;
    #1;
    chk({tag, "_rsp_dropped"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_idle"}, 32'(arb_busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL tb_global_timeout observed=running expected=finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    int g;
    int done;
    int cyc;
    bit drop;
    int order[4];
    order = '{0, 1, 0, 1};

    rst_n             = 1'b0;
    bus.req_valid     = '0;
    bus.req_dividend  = '0;
    bus.req_divisor   = '0;
    bus.req_is_8_bit  = '0;
    bus.req_is_signed = '0;
    bus.rsp_ready     = '0;

    // Reset: everything quiet even with requests pending.
    repeat (3) @(negedge clk);
    bus.req_valid       = 2'b11;
    bus.req_dividend[0] = 32'd1000;    bus.req_divisor[0] = 16'd10;
    bus.req_dividend[1] = 32'h00012345; bus.req_divisor[1] = 16'h0100;
    #1;
    chk("reset_busy", 32'(arb_busy), 32'd0);
    chk("reset_start", 32'(div_start), 32'd0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset_dividend", div_dividend, 32'd0);
    chk("reset_quotient", 32'(bus.rsp_quotient), 32'd0);
    chk("reset_error", 32'(bus.rsp_error), 32'd0);

    // Simultaneous continuous requests alternate 0,1,0,1.
    @(negedge clk);
    rst_n = 1'b1;
    g = 0; done = 0; cyc = 0; drop = 1'b0;
    while (done < 4 && cyc < 400) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      bus.rsp_ready = '0;
      if (drop) begin
        bus.req_valid = '0;
        drop = 1'b0;
      end
      #1;
      if (bus.req_ready != '0) begin
        chk("sim_grant_when_idle", 32'(arb_busy), 32'd0);
        if (g < 4) begin
          chk("sim_order", 32'(bus.req_ready), 32'(1) << order[g]);
          if (order[g] == 0) sb.push_back('{req: 0, q: 16'd100, r: 16'd0, err: 1'b0, to: 1'b0});
          else               sb.push_back('{req: 1, q: 16'h0123, r: 16'h0045, err: 1'b0, to: 1'b0});
        end else begin
          chk("sim_extra_grant", 32'(bus.req_ready), 32'd0);
        end
        g++;
        if (g == 4) drop = 1'b1;
      end
      if (bus.rsp_valid != '0) begin
        sb_check("sim");
        bus.rsp_ready = bus.rsp_valid;
        done++;
      end
    end
    chk("sim_done", 32'(done), 32'd4);
    @(negedge clk);
    bus.rsp_ready = '0;

    run_op("single16", 0, 32'h000186A0, 16'd7, 1'b0, 1'b0, 16'h37CD, 16'd5, 1'b0, 1'b0, DIV_LAT + 1, 0, 1'b0);
    run_op("divzero", 1, 32'd1234, 16'd0, 1'b0, 1'b1, 16'd0, 16'd0, 1'b1, 1'b0, 2, 0, 1'b0);
    run_op("div8", 0, 32'h00000064, 16'd7, 1'b1, 1'b0, 16'h000E, 16'd2, 1'b0, 1'b0, DIV_LAT + 1, 0, 1'b0);
    run_op("backpressure", 1, 32'h0000FFFF, 16'h0010, 1'b0, 1'b0, 16'h0FFF, 16'h000F, 1'b0, 1'b0, DIV_LAT + 1, 10, 1'b0);
    hang = 1'b1;
    run_op("watchdog", 0, 32'd50, 16'd5, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 1'b1, TIMEOUT + 1, 0, 1'b0);
    hang = 1'b0;

    // Reset in WAIT: pointer now favours requester 1; after reset requester 0 must win.
    @(negedge clk);
    bus.req_valid[1]    = 1'b1;
    bus.req_dividend[1] = 32'd500;
    bus.req_divisor[1]  = 16'd4;
    bus.req_is_8_bit[1] = 1'b0;
    #1;
    chk("rst_pre_grant", 32'(bus.req_ready), 32'd2);
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("rst_in_wait", 32'(arb_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(arb_busy), 32'd0);
    chk("rst_start", 32'(div_start), 32'd0);
    chk("rst_dividend", div_dividend, 32'd0);
    chk("rst_divisor", 32'(div_divisor), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_flags", 32'({bus.rsp_error, bus.rsp_timeout}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 0, 32'd81, 16'd9, 1'b0, 1'b0, 16'd9, 16'd0, 1'b0, 1'b0, DIV_LAT + 1, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
